sha_msg_sequencer: RTL and testbench

- Sequences 512-bit padded blocks from two block sources (each a padder instance) into one shared SHA-256 compression core.
- Arbitrates at message granularity. Once a requester is granted, all of its blocks up to and including the last run before the other requester is served.
- Owns the 256-bit chaining value: loads the IV at message start and updates it after every block.
- Returns the final digest, tagged with the requester id, over a valid/ready port.

---
 rtl/sha_msg_sequencer.sv | 135 +++++++++++++
 tb/tb_sha_msg_sequencer.sv | 345 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sha_msg_sequencer.sv
// Feeds padded 512-bit blocks from two requesters into one SHA-256 compression core,
// locking the core to one message at a time and returning the tagged final digest.
module sha_msg_sequencer #(
    parameter logic [255:0] IV = 256'h6a09e667bb67ae853c6ef372a54ff53a510e527f9b05688c1f83d9ab5be0cd19
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         req0_blk_valid,
    output logic         req0_blk_ready,
    input  logic [511:0] req0_blk_data,
    input  logic         req0_blk_last,
    input  logic         req1_blk_valid,
    output logic         req1_blk_ready,
    input  logic [511:0] req1_blk_data,
    input  logic         req1_blk_last,
    output logic         core_start,
    output logic [511:0] core_blk,
    output logic [255:0] core_hash_in,
    input  logic         core_done,
    input  logic [255:0] core_hash_out,
    output logic         dig_valid,
    input  logic         dig_ready,
    output logic [255:0] dig_data,
    output logic         dig_id
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_BUSY,
        S_NEXT,
        S_OUT
    } state_t;

    state_t        state_q, state_d;
    logic [255:0]  chain_q, chain_d;
    logic [511:0]  blk_reg_q, blk_reg_d;
    logic          last_reg_q, last_reg_d;
    logic          owner_q, owner_d;
    logic          rr_ptr_q, rr_ptr_d;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= S_IDLE;
            chain_q    <= IV;
            blk_reg_q  <= '0;
            last_reg_q <= 1'b0;
            owner_q    <= 1'b0;
            rr_ptr_q   <= 1'b0;
        end else begin
            state_q    <= state_d;
            chain_q    <= chain_d;
            blk_reg_q  <= blk_reg_d;
            last_reg_q <= last_reg_d;
            owner_q    <= owner_d;
            rr_ptr_q   <= rr_ptr_d;
        end
    end

    always_comb begin
        state_d        = state_q;
        chain_d        = chain_q;
        blk_reg_d      = blk_reg_q;
        last_reg_d     = last_reg_q;
        owner_d        = owner_q;
        rr_ptr_d       = rr_ptr_q;
        req0_blk_ready = 1'b0;
        req1_blk_ready = 1'b0;
        core_start     = 1'b0;
        dig_valid      = 1'b0;
        dig_data       = '0;
        dig_id         = 1'b0;

        case (state_q)
            S_IDLE: begin
                chain_d = IV;
                // Tie between two valid requesters goes to rr_ptr
                req0_blk_ready = req0_blk_valid & (!rr_ptr_q | !req1_blk_valid);
                req1_blk_ready = req1_blk_valid & (rr_ptr_q | !req0_blk_valid);
                if (req0_blk_ready) begin
                    blk_reg_d  = req0_blk_data;
                    last_reg_d = req0_blk_last;
                    owner_d    = 1'b0;
                    state_d    = S_START;
                end else if (req1_blk_ready) begin
                    blk_reg_d  = req1_blk_data;
                    last_reg_d = req1_blk_last;
                    owner_d    = 1'b1;
                    state_d    = S_START;
                end
            end
            S_START: begin
                core_start = 1'b1;
                state_d    = S_BUSY;
            end
            S_BUSY: begin
                if (core_done) begin
                    chain_d = core_hash_out;
                    state_d = last_reg_q ? S_OUT : S_NEXT;
                end
            end
            S_NEXT: begin
                // Mid-message: only the owner may hand over its next block
                req0_blk_ready = req0_blk_valid & !owner_q;
                req1_blk_ready = req1_blk_valid & owner_q;
                if (req0_blk_ready) begin
                    blk_reg_d  = req0_blk_data;
                    last_reg_d = req0_blk_last;
                    state_d    = S_START;
                end else if (req1_blk_ready) begin
                    blk_reg_d  = req1_blk_data;
                    last_reg_d = req1_blk_last;
                    state_d    = S_START;
                end
            end
            S_OUT: begin
                dig_valid = 1'b1;
                dig_data  = chain_q;
                dig_id    = owner_q;
                if (dig_ready) begin
                    rr_ptr_d = ~owner_q;
                    chain_d  = IV;
                    state_d  = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    assign core_blk     = blk_reg_q;
    assign core_hash_in = chain_q;

endmodule

// File: tb/tb_sha_msg_sequencer.sv
// Scoreboard bench for sha_msg_sequencer with a behavioural SHA-256 compression core.
module tb_sha_msg_sequencer;

    localparam logic [255:0] IV       = 256'h6a09e667bb67ae853c6ef372a54ff53a510e527f9b05688c1f83d9ab5be0cd19;
    localparam logic [255:0] DIG_ABC  = 256'hba7816bf8f01cfea414140de5dae2223b00361a396177a9cb410ff61f20015ad;
    localparam logic [255:0] DIG_TWO  = 256'h248d6a61d20638b8e5c026930c3e6039a33ce45964ff2167f6ecedd419db06c1;
    localparam logic [511:0] BLK_ABC  = {32'h61626380, 448'h0, 32'h00000018};
    localparam logic [511:0] BLK_T1   = {32'h61626364, 32'h62636465, 32'h63646566, 32'h64656667,
                                         32'h65666768, 32'h66676869, 32'h6768696a, 32'h68696a6b,
                                         32'h696a6b6c, 32'h6a6b6c6d, 32'h6b6c6d6e, 32'h6c6d6e6f,
                                         32'h6d6e6f70, 32'h6e6f7071, 32'h80000000, 32'h00000000};
    localparam logic [511:0] BLK_T2   = {448'h0, 64'h00000000000001c0};

    localparam logic [31:0] K [0:63] = '{
        32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
        32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
        32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
        32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
        32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
        32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
        32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
        32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
    };

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         req0_blk_valid = 1'b0, req1_blk_valid = 1'b0;
    logic         req0_blk_ready, req1_blk_ready;
    logic [511:0] req0_blk_data = '0, req1_blk_data = '0;
    logic         req0_blk_last = 1'b0, req1_blk_last = 1'b0;
    logic         core_start;
    logic [511:0] core_blk;
    logic [255:0] core_hash_in;
    logic         core_done;
    logic [255:0] core_hash_out;
    logic         dig_valid;
    logic         dig_ready = 1'b1;
    logic [255:0] dig_data;
    logic         dig_id;

    logic         model_done = 1'b0, inj_done = 1'b0;
    logic [255:0] model_hash = '0, inj_hash = '0;
    logic [255:0] last_out = '0;
    logic         abort_core = 1'b0;
    logic         active = 1'b0, active_id = 1'b0;
    int           errors = 0, checks = 0, starts = 0;

    typedef struct { logic [511:0] blk; logic first; } acc_t;
    typedef struct { logic [255:0] dig; logic id; } dig_t;
    acc_t acc_q[$];
    dig_t exp_q[$];

    assign core_done     = model_done | inj_done;
    assign core_hash_out = inj_done ? inj_hash : model_hash;

    always #5 clk = ~clk;

    sha_msg_sequencer dut (
        .clk(clk), .rst(rst),
        .req0_blk_valid(req0_blk_valid), .req0_blk_ready(req0_blk_ready),
        .req0_blk_data(req0_blk_data), .req0_blk_last(req0_blk_last),
        .req1_blk_valid(req1_blk_valid), .req1_blk_ready(req1_blk_ready),
        .req1_blk_data(req1_blk_data), .req1_blk_last(req1_blk_last),
        .core_start(core_start), .core_blk(core_blk), .core_hash_in(core_hash_in),
        .core_done(core_done), .core_hash_out(core_hash_out),
        .dig_valid(dig_valid), .dig_ready(dig_ready), .dig_data(dig_data), .dig_id(dig_id)
    );

    task automatic chk1(input string nm, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %b expected %b", nm, act, exp);
        end
    endtask

    task automatic chk256(input string nm, input logic [255:0] act, input logic [255:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic chk512(input string nm, input logic [511:0] act, input logic [511:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic fail_now(input string nm);
        checks++;
        errors++;
        $display("FAIL %s: timeout or missing expectation", nm);
    endtask

    function automatic logic [31:0] rotr(input logic [31:0] x, input int n);
        return (x >> n) | (x << (32 - n));
    endfunction

    function automatic logic [255:0] sha_compress(input logic [255:0] h, input logic [511:0] blk);
        logic [31:0] w [64];
        logic [31:0] a, b, c, d, e, f, g, hh, t1, t2;
        for (int i = 0; i < 16; i++) w[i] = blk[511 - 32*i -: 32];
        for (int i = 16; i < 64; i++)
            w[i] = w[i-16] + (rotr(w[i-15], 7) ^ rotr(w[i-15], 18) ^ (w[i-15] >> 3))
                 + w[i-7] + (rotr(w[i-2], 17) ^ rotr(w[i-2], 19) ^ (w[i-2] >> 10));
        {a, b, c, d, e, f, g, hh} = h;
        for (int i = 0; i < 64; i++) begin
            t1 = hh + (rotr(e, 6) ^ rotr(e, 11) ^ rotr(e, 25)) + ((e & f) ^ (~e & g)) + K[i] + w[i];
            t2 = (rotr(a, 2) ^ rotr(a, 13) ^ rotr(a, 22)) + ((a & b) ^ (a & c) ^ (b & c));
            hh = g; g = f; f = e; e = d + t1; d = c; c = b; b = a; a = t1 + t2;
        end
        return {h[255:224] + a, h[223:192] + b, h[191:160] + c, h[159:128] + d,
                h[127:96] + e, h[95:64] + f, h[63:32] + g, h[31:0] + hh};
    endfunction

    // Present one block and hold it until the sequencer accepts it.
    task automatic send_block(input logic id, input logic [511:0] data, input logic last, input logic first);
        int n;
        acc_t a;
        if (id == 1'b0) begin
            req0_blk_valid = 1'b1; req0_blk_data = data; req0_blk_last = last;
        end else begin
            req1_blk_valid = 1'b1; req1_blk_data = data; req1_blk_last = last;
        end
        #1;
        n = 0;
        while (!(id ? req1_blk_ready : req0_blk_ready) && n < 500) begin
            @(posedge clk); #1;
            n++;
        end
        if (!(id ? req1_blk_ready : req0_blk_ready)) begin
            fail_now(id ? "req1_accept" : "req0_accept");
            if (id == 1'b0) req0_blk_valid = 1'b0; else req1_blk_valid = 1'b0;
            return;
        end
        a.blk = data;
        a.first = first;
        acc_q.push_back(a);
        if (first) begin
            active = 1'b1;
            active_id = id;
        end
        @(posedge clk); #1;
        if (id == 1'b0) req0_blk_valid = 1'b0; else req1_blk_valid = 1'b0;
        chk1("core_start_latency", core_start, 1'b1);
    endtask

    task automatic wait_drain(input string nm);
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < 1000) begin
            @(posedge clk);
            n++;
        end
        if (exp_q.size() != 0) begin
            fail_now(nm);
            exp_q.delete();
        end
        repeat (2) @(posedge clk);
        #1;
    endtask

    task automatic pulse_reset();
        @(posedge clk); #1;
        rst = 1'b1;
        abort_core = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        acc_q.delete();
        active = 1'b0;
    endtask

    // Compression core model: fixed 64-cycle latency, feed-forward included.
    initial begin
        acc_t a;
        logic [511:0] cap_blk;
        logic [255:0] cap_hin;
        logic ok;
        forever begin
            @(posedge clk); #1;
            if (core_start) begin
                abort_core = 1'b0;
                starts++;
                cap_blk = core_blk;
                cap_hin = core_hash_in;
                if (acc_q.size() == 0) begin
                    fail_now("core_start_unexpected");
                end else begin
                    a = acc_q.pop_front();
                    chk512("core_blk", cap_blk, a.blk);
                    chk256("core_hash_in", cap_hin, a.first ? IV : last_out);
                end
                ok = 1'b1;
                for (int i = 1; i < 64; i++) begin
                    @(posedge clk); #1;
                    if (abort_core) begin
                        ok = 1'b0;
                        abort_core = 1'b0;
                        break;
                    end
                    if (i == 1) chk1("core_start_single", core_start, 1'b0);
                end
                if (ok) begin
                    chk512("core_blk_stable", core_blk, cap_blk);
                    chk256("core_hash_in_stable", core_hash_in, cap_hin);
                    model_hash = sha_compress(cap_hin, cap_blk);
                    model_done = 1'b1;
                    @(posedge clk); #1;
                    model_done = 1'b0;
                    last_out = model_hash;
                end
            end
        end
    end

    // Monitor: digest scoreboard and arbitration/lock invariants.
    initial begin
        dig_t e;
        forever begin
            @(negedge clk);
            if (!rst) begin
                if (req0_blk_valid && req1_blk_valid)
                    chk1("single_ready", req0_blk_ready & req1_blk_ready, 1'b0);
                if (active && (active_id ? req0_blk_valid : req1_blk_valid))
                    chk1("message_lock", active_id ? req0_blk_ready : req1_blk_ready, 1'b0);
                if (dig_valid && dig_ready) begin
                    if (exp_q.size() == 0) begin
                        fail_now("digest_unexpected");
                    end else begin
                        e = exp_q.pop_front();
                        chk256("dig_data", dig_data, e.dig);
                        chk1("dig_id", dig_id, e.id);
                    end
                    active = 1'b0;
                end
            end
        end
    end

    initial begin
        dig_t e;
        logic [255:0] d0;
        logic i0;
        int n;

        repeat (3) @(posedge clk);
        #1 rst = 1'b0;

        // Idle after reset
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            chk1("rst_req0_ready", req0_blk_ready, 1'b0);
            chk1("rst_req1_ready", req1_blk_ready, 1'b0);
            chk1("rst_core_start", core_start, 1'b0);
            chk1("rst_dig_valid", dig_valid, 1'b0);
            chk256("rst_dig_data", dig_data, 256'h0);
            chk256("rst_core_hash_in", core_hash_in, IV);
            chk512("rst_core_blk", core_blk, 512'h0);
        end
        @(posedge clk); #1;

        // Single-block "abc" on requester 0
        e.dig = DIG_ABC; e.id = 1'b0; exp_q.push_back(e);
        send_block(1'b0, BLK_ABC, 1'b1, 1'b1);
        wait_drain("abc_req0_digest");

        // Two-block message on requester 1
        e.dig = DIG_TWO; e.id = 1'b1; exp_q.push_back(e);
        send_block(1'b1, BLK_T1, 1'b0, 1'b1);
        send_block(1'b1, BLK_T2, 1'b1, 1'b0);
        wait_drain("two_block_req1_digest");

        // Contention right after reset: requester 0 wins and holds the core
        pulse_reset();
        e.dig = DIG_TWO; e.id = 1'b0; exp_q.push_back(e);
        e.dig = DIG_ABC; e.id = 1'b1; exp_q.push_back(e);
        fork
            begin
                send_block(1'b0, BLK_T1, 1'b0, 1'b1);
                send_block(1'b0, BLK_T2, 1'b1, 1'b0);
            end
            send_block(1'b1, BLK_ABC, 1'b1, 1'b1);
        join
        wait_drain("contention_digests");

        // Digest back-pressure with a stray core_done
        dig_ready = 1'b0;
        e.dig = DIG_ABC; e.id = 1'b0; exp_q.push_back(e);
        send_block(1'b0, BLK_ABC, 1'b1, 1'b1);
        n = 0;
        while (!dig_valid && n < 200) begin
            @(posedge clk); #1;
            n++;
        end
        if (!dig_valid) fail_now("stall_dig_valid");
        d0 = dig_data;
        i0 = dig_id;
        chk256("stall_dig_data_value", d0, DIG_ABC);
        req1_blk_valid = 1'b1; req1_blk_data = BLK_ABC; req1_blk_last = 1'b1;
        for (int c = 0; c < 10; c++) begin
            @(posedge clk); #1;
            inj_done = (c == 3);
            inj_hash = 256'hdeadbeef_00000000_deadbeef_00000000_deadbeef_00000000_deadbeef_00000000;
            chk1("stall_dig_valid_held", dig_valid, 1'b1);
            chk256("stall_dig_data_held", dig_data, d0);
            chk1("stall_dig_id_held", dig_id, i0);
            chk1("stall_req1_ready", req1_blk_ready, 1'b0);
        end
        inj_done = 1'b0;
        req1_blk_valid = 1'b0;
        dig_ready = 1'b1;
        wait_drain("stall_digest");

        // Reset while the core is busy, then a clean message
        send_block(1'b0, BLK_ABC, 1'b1, 1'b1);
        repeat (5) @(posedge clk);
        pulse_reset();
        @(negedge clk);
        chk1("busy_rst_core_start", core_start, 1'b0);
        chk1("busy_rst_dig_valid", dig_valid, 1'b0);
        chk1("busy_rst_req0_ready", req0_blk_ready, 1'b0);
        chk256("busy_rst_hash_in", core_hash_in, IV);
        chk512("busy_rst_core_blk", core_blk, 512'h0);
        repeat (80) @(posedge clk);
        #1;
        chk1("busy_rst_no_digest", dig_valid, 1'b0);
        e.dig = DIG_ABC; e.id = 1'b0; exp_q.push_back(e);
        send_block(1'b0, BLK_ABC, 1'b1, 1'b1);
        wait_drain("post_reset_digest");

        checks++;
        if (starts != 9) begin
            errors++;
            $display("FAIL core_start_count: got %0d expected 9", starts);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
